decoder: RTL and testbench



---
 rtl/decoder_pkg.sv | 100 ++++++++++
 rtl/decoder_imm_gen.sv | 37 +++
 rtl/decoder.sv | 168 ++++++++++++++++
 tb/tb_decoder.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/decoder_pkg.sv
// decoder_pkg: shared constants and types for the RV32I decode stage.
//  - Opcode encodings, funct3 values, widths of the one-hot output vectors.
//  - Bit positions of the one-hot opcode class, ALU op and exception vectors.
//  - opcode_class(): maps the 7-bit major opcode to the one-hot class vector.
package decoder_pkg;

    localparam int ALU_WIDTH       = 14;
    localparam int OPCODE_WIDTH    = 11;
    localparam int EXCEPTION_WIDTH = 4;

    localparam logic [6:0] OPCODE_RTYPE  = 7'b0110011;
    localparam logic [6:0] OPCODE_ITYPE  = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPCODE_SYSTEM = 7'b1110011;
    localparam logic [6:0] OPCODE_FENCE  = 7'b0001111;

    // Arithmetic funct3 (shared by RTYPE and ITYPE)
    localparam logic [2:0] FUNCT3_ADD_SUB = 3'b000;
    localparam logic [2:0] FUNCT3_SLL     = 3'b001;
    localparam logic [2:0] FUNCT3_SLT     = 3'b010;
    localparam logic [2:0] FUNCT3_SLTU    = 3'b011;
    localparam logic [2:0] FUNCT3_XOR     = 3'b100;
    localparam logic [2:0] FUNCT3_SRL_SRA = 3'b101;
    localparam logic [2:0] FUNCT3_OR      = 3'b110;
    localparam logic [2:0] FUNCT3_AND     = 3'b111;

    // Branch funct3
    localparam logic [2:0] FUNCT3_BEQ  = 3'b000;
    localparam logic [2:0] FUNCT3_BNE  = 3'b001;
    localparam logic [2:0] FUNCT3_BLT  = 3'b100;
    localparam logic [2:0] FUNCT3_BGE  = 3'b101;
    localparam logic [2:0] FUNCT3_BLTU = 3'b110;
    localparam logic [2:0] FUNCT3_BGEU = 3'b111;

    typedef enum logic [3:0] {
        OPC_RTYPE  = 4'd0,
        OPC_ITYPE  = 4'd1,
        OPC_LOAD   = 4'd2,
        OPC_STORE  = 4'd3,
        OPC_BRANCH = 4'd4,
        OPC_JAL    = 4'd5,
        OPC_JALR   = 4'd6,
        OPC_LUI    = 4'd7,
        OPC_AUIPC  = 4'd8,
        OPC_SYSTEM = 4'd9,
        OPC_FENCE  = 4'd10
    } opc_idx_e;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_SLT  = 4'd2,
        ALU_SLTU = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_OR   = 4'd5,
        ALU_AND  = 4'd6,
        ALU_SLL  = 4'd7,
        ALU_SRL  = 4'd8,
        ALU_SRA  = 4'd9,
        ALU_EQ   = 4'd10,
        ALU_NEQ  = 4'd11,
        ALU_GE   = 4'd12,
        ALU_GEU  = 4'd13
    } alu_idx_e;

    typedef enum logic [1:0] {
        EXC_ILLEGAL = 2'd0,
        EXC_ECALL   = 2'd1,
        EXC_EBREAK  = 2'd2,
        EXC_MRET    = 2'd3
    } exc_idx_e;

    // All-zero result means the opcode is not one RV32I defines.
    function automatic logic [OPCODE_WIDTH-1:0] opcode_class(input logic [6:0] op);
        logic [OPCODE_WIDTH-1:0] oh;
        oh = '0;
        case (op)
            OPCODE_RTYPE:  oh[OPC_RTYPE]  = 1'b1;
            OPCODE_ITYPE:  oh[OPC_ITYPE]  = 1'b1;
            OPCODE_LOAD:   oh[OPC_LOAD]   = 1'b1;
            OPCODE_STORE:  oh[OPC_STORE]  = 1'b1;
            OPCODE_BRANCH: oh[OPC_BRANCH] = 1'b1;
            OPCODE_JAL:    oh[OPC_JAL]    = 1'b1;
            OPCODE_JALR:   oh[OPC_JALR]   = 1'b1;
            OPCODE_LUI:    oh[OPC_LUI]    = 1'b1;
            OPCODE_AUIPC:  oh[OPC_AUIPC]  = 1'b1;
            OPCODE_SYSTEM: oh[OPC_SYSTEM] = 1'b1;
            OPCODE_FENCE:  oh[OPC_FENCE]  = 1'b1;
            default:       oh = '0;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/decoder_imm_gen.sv
// decoder_imm_gen: combinational immediate generator.
//  instr in IWIDTH : raw instruction
//  imm   out DWIDTH: immediate for the instruction's format, sign-extended from bit 31
//                    (RTYPE and unknown opcodes give 0; SYSTEM/FENCE use the I layout)
module decoder_imm_gen
    import decoder_pkg::*;
#(
    parameter int DWIDTH = 32,
    parameter int IWIDTH = 32
) (
    input  logic [IWIDTH-1:0] instr,
    output logic [DWIDTH-1:0] imm
);

    logic [OPCODE_WIDTH-1:0] opc;
    logic [31:0]             imm32;

    assign opc = opcode_class(instr[6:0]);

    // NOTE: every variable written here gets a default first, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        imm32 = '0;
        if (opc[OPC_ITYPE] || opc[OPC_LOAD] || opc[OPC_JALR] || opc[OPC_SYSTEM] || opc[OPC_FENCE])
            imm32 = {{20{instr[31]}}, instr[31:20]};
        else if (opc[OPC_STORE])
            imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
        else if (opc[OPC_BRANCH])
            imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
        else if (opc[OPC_JAL])
            imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
        else if (opc[OPC_LUI] || opc[OPC_AUIPC])
            imm32 = {instr[31:12], 12'b0};
    end

    assign imm = DWIDTH'($signed(imm32));

endmodule

// File: rtl/decoder.sv
// decoder: RV32I instruction-decode pipeline stage (fetch -> execute).
//  d_clk / d_rst            : clock (rising edge), asynchronous active-high reset
//  d_i_instr, d_i_pc, d_i_ce: instruction, its PC, input valid
//  d_i_stall, d_i_flush     : hold stage / kill stage (passed through on d_o_stall / d_o_flush)
//  d_o_addr_*_p             : combinational register addresses for the regfile read
//  d_o_pc, d_o_addr_*, d_o_imm, d_o_funct3, d_o_alu (one-hot), d_o_opcode (one-hot),
//  d_o_exception, d_o_ce    : registered decode results, one cycle after capture
// Build option: DECODER_EXCEPTION_EN enables illegal/ECALL/EBREAK/MRET detection;
//  without it d_o_exception is constant 0.
module decoder
    import decoder_pkg::*;
#(
    parameter int DWIDTH   = 32,
    parameter int IWIDTH   = 32,
    parameter int AWIDTH   = 5,
    parameter int PC_WIDTH = 32
) (
    input  logic                       d_clk,
    input  logic                       d_rst,
    input  logic [IWIDTH-1:0]          d_i_instr,
    input  logic [PC_WIDTH-1:0]        d_i_pc,
    input  logic                       d_i_ce,
    input  logic                       d_i_stall,
    input  logic                       d_i_flush,
    output logic [PC_WIDTH-1:0]        d_o_pc,
    output logic [AWIDTH-1:0]          d_o_addr_rs1,
    output logic [AWIDTH-1:0]          d_o_addr_rs2,
    output logic [AWIDTH-1:0]          d_o_addr_rd,
    output logic [AWIDTH-1:0]          d_o_addr_rs1_p,
    output logic [AWIDTH-1:0]          d_o_addr_rs2_p,
    output logic [AWIDTH-1:0]          d_o_addr_rd_p,
    output logic [DWIDTH-1:0]          d_o_imm,
    output logic [2:0]                 d_o_funct3,
    output logic [ALU_WIDTH-1:0]       d_o_alu,
    output logic [OPCODE_WIDTH-1:0]    d_o_opcode,
    output logic [EXCEPTION_WIDTH-1:0] d_o_exception,
    output logic                       d_o_ce,
    output logic                       d_o_stall,
    output logic                       d_o_flush
);

    logic [OPCODE_WIDTH-1:0]    opc;
    logic [2:0]                 funct3;
    logic [DWIDTH-1:0]          imm;
    logic [ALU_WIDTH-1:0]       alu_dec;
    logic [EXCEPTION_WIDTH-1:0] exc;

    assign opc       = opcode_class(d_i_instr[6:0]);
    assign funct3    = d_i_instr[14:12];
    assign d_o_stall = d_i_stall;
    assign d_o_flush = d_i_flush;

    // Fields an instruction format does not carry read as x0.
    assign d_o_addr_rs1_p = (opc[OPC_LUI] || opc[OPC_AUIPC] || opc[OPC_JAL]) ? '0 : AWIDTH'(d_i_instr[19:15]);
    assign d_o_addr_rs2_p = (opc[OPC_RTYPE] || opc[OPC_STORE] || opc[OPC_BRANCH]) ? AWIDTH'(d_i_instr[24:20]) : '0;
    assign d_o_addr_rd_p  = (opc[OPC_STORE] || opc[OPC_BRANCH]) ? '0 : AWIDTH'(d_i_instr[11:7]);

    decoder_imm_gen #(
        .DWIDTH (DWIDTH),
        .IWIDTH (IWIDTH)
    ) u_imm_gen (
        .instr (d_i_instr),
        .imm   (imm)
    );

    // Bit 30 is funct7[5]: selects SUB/SRA in RTYPE and SRAI in ITYPE (ITYPE has no SUBI).
    always_comb begin
        alu_dec = '0;
        if (opc[OPC_RTYPE] || opc[OPC_ITYPE]) begin
            case (funct3)
                FUNCT3_ADD_SUB: begin
                    if (opc[OPC_RTYPE] && d_i_instr[30]) alu_dec[ALU_SUB] = 1'b1;
                    else                                 alu_dec[ALU_ADD] = 1'b1;
                end
                FUNCT3_SLL:  alu_dec[ALU_SLL]  = 1'b1;
                FUNCT3_SLT:  alu_dec[ALU_SLT]  = 1'b1;
                FUNCT3_SLTU: alu_dec[ALU_SLTU] = 1'b1;
                FUNCT3_XOR:  alu_dec[ALU_XOR]  = 1'b1;
                FUNCT3_SRL_SRA: begin
                    if (d_i_instr[30]) alu_dec[ALU_SRA] = 1'b1;
                    else               alu_dec[ALU_SRL] = 1'b1;
                end
                FUNCT3_OR:   alu_dec[ALU_OR]   = 1'b1;
                default:     alu_dec[ALU_AND]  = 1'b1;
            endcase
        end else if (opc[OPC_BRANCH]) begin
            case (funct3)
                FUNCT3_BEQ:  alu_dec[ALU_EQ]   = 1'b1;
                FUNCT3_BNE:  alu_dec[ALU_NEQ]  = 1'b1;
                FUNCT3_BLT:  alu_dec[ALU_SLT]  = 1'b1;
                FUNCT3_BGE:  alu_dec[ALU_GE]   = 1'b1;
                FUNCT3_BLTU: alu_dec[ALU_SLTU] = 1'b1;
                FUNCT3_BGEU: alu_dec[ALU_GEU]  = 1'b1;
                default:     alu_dec = '0;
            endcase
        end else if (opc[OPC_LOAD] || opc[OPC_STORE] || opc[OPC_JAL] || opc[OPC_JALR] ||
                     opc[OPC_LUI]  || opc[OPC_AUIPC]) begin
            alu_dec[ALU_ADD] = 1'b1;
        end
    end

`ifdef DECODER_EXCEPTION_EN
    logic [6:0] funct7;
    logic       illegal;

    assign funct7 = d_i_instr[31:25];

    always_comb begin
        illegal = (opc == '0);
        if (opc[OPC_LOAD])
            illegal = (funct3 == 3'b011) || (funct3 == 3'b110) || (funct3 == 3'b111);
        else if (opc[OPC_STORE])
            illegal = (funct3 > 3'b010);
        else if (opc[OPC_BRANCH])
            illegal = (funct3 == 3'b010) || (funct3 == 3'b011);
        else if (opc[OPC_JALR])
            illegal = (funct3 != 3'b000);
        else if (opc[OPC_RTYPE])
            // Only ADD/SUB and SRL/SRA accept the alternate funct7.
            illegal = !((funct7 == 7'b0000000) ||
                        ((funct7 == 7'b0100000) &&
                         ((funct3 == FUNCT3_ADD_SUB) || (funct3 == FUNCT3_SRL_SRA))));

        exc              = '0;
        exc[EXC_ILLEGAL] = illegal;
        exc[EXC_ECALL]   = (d_i_instr[31:0] == 32'h0000_0073);
        exc[EXC_EBREAK]  = (d_i_instr[31:0] == 32'h0010_0073);
        exc[EXC_MRET]    = (d_i_instr[31:0] == 32'h3020_0073);
    end
`else
    assign exc = '0;
`endif

    // Flush and a plain bubble only drop d_o_ce; the data registers keep the last decode.
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge d_clk or posedge d_rst) begin
        if (d_rst) begin
            d_o_ce        <= 1'b0;
            d_o_pc        <= '0;
            d_o_addr_rs1  <= '0;
            d_o_addr_rs2  <= '0;
            d_o_addr_rd   <= '0;
            d_o_imm       <= '0;
            d_o_funct3    <= '0;
            d_o_alu       <= '0;
            d_o_opcode    <= '0;
            d_o_exception <= '0;
        end else if (d_i_flush) begin
            d_o_ce <= 1'b0;
        end else if (d_i_stall) begin
            d_o_ce <= d_o_ce;
        end else if (d_i_ce) begin
            d_o_ce        <= 1'b1;
            d_o_pc        <= d_i_pc;
            d_o_addr_rs1  <= d_o_addr_rs1_p;
            d_o_addr_rs2  <= d_o_addr_rs2_p;
            d_o_addr_rd   <= d_o_addr_rd_p;
            d_o_imm       <= imm;
            d_o_funct3    <= funct3;
            d_o_alu       <= (exc != '0) ? '0 : alu_dec;
            d_o_opcode    <= opc;
            d_o_exception <= exc;
        end else begin
            d_o_ce <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decoder.sv
// tb_decoder: scoreboard bench for the decode stage. The driver pushes the reference
// decode of every instruction it expects to be captured; the monitor pops it on the
// capturing edge and compares the registered outputs every cycle until the next capture.
module tb_decoder;

    logic        d_clk;
    logic        d_rst;
    logic [31:0] d_i_instr;
    logic [31:0] d_i_pc;
    logic        d_i_ce;
    logic        d_i_stall;
    logic        d_i_flush;
    logic [31:0] d_o_pc;
    logic [4:0]  d_o_addr_rs1, d_o_addr_rs2, d_o_addr_rd;
    logic [4:0]  d_o_addr_rs1_p, d_o_addr_rs2_p, d_o_addr_rd_p;
    logic [31:0] d_o_imm;
    logic [2:0]  d_o_funct3;
    logic [13:0] d_o_alu;
    logic [10:0] d_o_opcode;
    logic [3:0]  d_o_exception;
    logic        d_o_ce, d_o_stall, d_o_flush;

    decoder dut (
        .d_clk          (d_clk),
        .d_rst          (d_rst),
        .d_i_instr      (d_i_instr),
        .d_i_pc         (d_i_pc),
        .d_i_ce         (d_i_ce),
        .d_i_stall      (d_i_stall),
        .d_i_flush      (d_i_flush),
        .d_o_pc         (d_o_pc),
        .d_o_addr_rs1   (d_o_addr_rs1),
        .d_o_addr_rs2   (d_o_addr_rs2),
        .d_o_addr_rd    (d_o_addr_rd),
        .d_o_addr_rs1_p (d_o_addr_rs1_p),
        .d_o_addr_rs2_p (d_o_addr_rs2_p),
        .d_o_addr_rd_p  (d_o_addr_rd_p),
        .d_o_imm        (d_o_imm),
        .d_o_funct3     (d_o_funct3),
        .d_o_alu        (d_o_alu),
        .d_o_opcode     (d_o_opcode),
        .d_o_exception  (d_o_exception),
        .d_o_ce         (d_o_ce),
        .d_o_stall      (d_o_stall),
        .d_o_flush      (d_o_flush)
    );

    initial begin
        d_clk = 1'b0;
        forever #5 d_clk = ~d_clk;
    end

    typedef struct packed {
        logic [31:0] pc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [2:0]  f3;
        logic [13:0] alu;
        logic [10:0] opc;
        logic [3:0]  exc;
    } exp_t;

    // Class positions in the one-hot opcode vector, in the order the classes are listed.
    localparam int R = 0, I = 1, LD = 2, ST = 3, BR = 4, JL = 5, JR = 6, LU = 7, AU = 8, SY = 9, FE = 10;
    localparam logic [6:0] OPC_CODE [11] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F,
                                              7'h67, 7'h37, 7'h17, 7'h73, 7'h0F};

    int   checks = 0;
    int   errors = 0;
    exp_t sbq[$];
    exp_t last_exp;
    logic exp_ce;
    logic mon_en;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Reference decode from the instruction-set rules (ALU positions: ADD0 SUB1 SLT2 SLTU3
    // XOR4 OR5 AND6 SLL7 SRL8 SRA9 EQ10 NEQ11 GE12 GEU13).
    function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc);
        exp_t               m;
        int                 k;
        int                 a;
        int                 arith [8] = '{0, 7, 2, 3, 4, 8, 5, 6};
        int                 brop  [8] = '{10, 11, -1, -1, 2, 12, 3, 13};
        logic signed [31:0] sx;
        logic [31:0]        sgn;
        logic [2:0]         f3;
        logic               illegal;
        m  = '0;
        k  = -1;
        f3 = i[14:12];
        sx = i;
        for (int n = 0; n < 11; n++) if (i[6:0] == OPC_CODE[n]) k = n;
        m.pc = pc;
        m.f3 = f3;
        if (k >= 0) m.opc[k] = 1'b1;
        m.rs1 = (k inside {LU, AU, JL}) ? 5'd0 : i[19:15];
        m.rs2 = (k inside {R, ST, BR}) ? i[24:20] : 5'd0;
        m.rd  = (k inside {ST, BR}) ? 5'd0 : i[11:7];
        sgn   = sx >>> 31;
        if (k inside {I, LD, JR, SY, FE}) m.imm = sx >>> 20;
        else if (k == ST) m.imm = (sgn << 12) | (32'(i[31:25]) << 5) | 32'(i[11:7]);
        else if (k == BR) m.imm = (sgn << 12) | (32'(i[7]) << 11) | (32'(i[30:25]) << 5) | (32'(i[11:8]) << 1);
        else if (k == JL) m.imm = (sgn << 20) | (32'(i[19:12]) << 12) | (32'(i[20]) << 11) | (32'(i[30:21]) << 1);
        else if (k inside {LU, AU}) m.imm = i & 32'hFFFF_F000;
        a = -1;
        if (k == R || k == I) begin
            a = arith[f3];
            if (k == R && f3 == 3'd0 && i[30]) a = 1;
            if (f3 == 3'd5 && i[30]) a = 9;
        end else if (k == BR) a = brop[f3];
        else if (k inside {LD, ST, JL, JR, LU, AU}) a = 0;
        if (a >= 0) m.alu[a] = 1'b1;
`ifdef DECODER_EXCEPTION_EN
        illegal = (k < 0) || (k == LD && f3 inside {3'd3, 3'd6, 3'd7}) || (k == ST && f3 > 3'd2) ||
                  (k == BR && f3 inside {3'd2, 3'd3}) || (k == JR && f3 != 3'd0) ||
                  (k == R && !(i[31:25] == 7'h00 || (i[31:25] == 7'h20 && f3 inside {3'd0, 3'd5})));
        m.exc = {i == 32'h3020_0073, i == 32'h0010_0073, i == 32'h0000_0073, illegal};
        if (m.exc != 0) m.alu = '0;
`else
        illegal = 1'b0;
        m.exc   = {3'b000, illegal};
`endif
        return m;
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int          sel;
        r   = $urandom;
        sel = $urandom_range(0, 15);
        if (sel < 11) r[6:0] = OPC_CODE[sel];
        else if (sel == 11) r[6:0] = 7'($urandom);
        else if (sel == 12) begin
            case ($urandom_range(0, 2))
                0:       r = 32'h0000_0073;
                1:       r = 32'h0010_0073;
                default: r = 32'h3020_0073;
            endcase
        end else r[6:0] = OPC_CODE[$urandom_range(0, 10)];
        if (r[6:0] == 7'h33 && $urandom_range(0, 3) != 0)
            r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00;
        return r;
    endfunction

    task automatic drive(input logic [31:0] ins, input logic [31:0] p,
                         input logic c, input logic s, input logic f);
        @(posedge d_clk);
        #1;
        d_i_instr = ins;
        d_i_pc    = p;
        d_i_ce    = c;
        d_i_stall = s;
        d_i_flush = f;
        if (c && !s && !f) sbq.push_back(model(ins, p));
    endtask

    // Monitor: control priority decided at the edge, outputs compared mid-cycle.
    initial begin
        logic en;
        exp_t pm;
        forever begin
            @(posedge d_clk);
            en = mon_en;
            if (en) begin
                if (d_rst) begin
                    exp_ce   = 1'b0;
                    last_exp = '0;
                end else if (d_i_flush) exp_ce = 1'b0;
                else if (d_i_stall) exp_ce = exp_ce;
                else if (d_i_ce) begin
                    check("sb_has_item", 32'(sbq.size() != 0), 32'd1);
                    if (sbq.size() != 0) last_exp = sbq.pop_front();
                    exp_ce = 1'b1;
                end else exp_ce = 1'b0;
            end
            @(negedge d_clk);
            if (en) begin
                check("o_ce",        32'(d_o_ce),        32'(exp_ce));
                check("o_pc",        d_o_pc,             last_exp.pc);
                check("o_rs1",       32'(d_o_addr_rs1),  32'(last_exp.rs1));
                check("o_rs2",       32'(d_o_addr_rs2),  32'(last_exp.rs2));
                check("o_rd",        32'(d_o_addr_rd),   32'(last_exp.rd));
                check("o_imm",       d_o_imm,            last_exp.imm);
                check("o_funct3",    32'(d_o_funct3),    32'(last_exp.f3));
                check("o_alu",       32'(d_o_alu),       32'(last_exp.alu));
                check("o_opcode",    32'(d_o_opcode),    32'(last_exp.opc));
                check("o_exception", 32'(d_o_exception), 32'(last_exp.exc));
                pm = model(d_i_instr, d_i_pc);
                check("rs1_p",       32'(d_o_addr_rs1_p), 32'(pm.rs1));
                check("rs2_p",       32'(d_o_addr_rs2_p), 32'(pm.rs2));
                check("rd_p",        32'(d_o_addr_rd_p),  32'(pm.rd));
                check("stall_pass",  32'(d_o_stall),      32'(d_i_stall));
                check("flush_pass",  32'(d_o_flush),      32'(d_i_flush));
            end
        end
    end

    logic [31:0] directed [11] = '{
        32'h003100B3, 32'h40628233, 32'h01040393, 32'h00452483, 32'h00B62423, 32'h00E68263,
        32'h010007EF, 32'h01488867, 32'h12345937, 32'hABCDE997, 32'h0000007F
    };

    initial begin
        logic s, f;
        d_rst     = 1'b1;
        d_i_instr = '0;
        d_i_pc    = '0;
        d_i_ce    = 1'b0;
        d_i_stall = 1'b0;
        d_i_flush = 1'b0;
        exp_ce    = 1'b0;
        last_exp  = '0;
        mon_en    = 1'b1;
        repeat (3) @(negedge d_clk);
        d_rst = 1'b0;

        for (int n = 0; n < 11; n++) begin
            drive(directed[n], 32'h1000 + 32'(n * 4), 1'b1, 1'b0, 1'b0);
            drive(directed[n], 32'h1000 + 32'(n * 4), 1'b0, 1'b0, 1'b0);
        end

        for (int n = 0; n < 1500; n++) begin
            s = ($urandom_range(0, 99) < 15);
            f = ($urandom_range(0, 99) < 10);
            drive(rand_instr(), $urandom, ($urandom_range(0, 99) < 75), s, f);
        end

        // Asynchronous reset in the middle of a cycle clears all registered outputs at once.
        drive(32'h003100B3, 32'h2000, 1'b1, 1'b0, 1'b0);
        @(posedge d_clk);
        #1;
        mon_en    = 1'b0;
        d_i_instr = rand_instr();
        d_i_ce    = 1'b1;
        @(negedge d_clk);
        #2;
        d_rst = 1'b1;
        #1;
        check("rst_ce",        32'(d_o_ce),        32'd0);
        check("rst_pc",        d_o_pc,             32'd0);
        check("rst_rs1",       32'(d_o_addr_rs1),  32'd0);
        check("rst_rs2",       32'(d_o_addr_rs2),  32'd0);
        check("rst_rd",        32'(d_o_addr_rd),   32'd0);
        check("rst_imm",       d_o_imm,            32'd0);
        check("rst_funct3",    32'(d_o_funct3),    32'd0);
        check("rst_alu",       32'(d_o_alu),       32'd0);
        check("rst_opcode",    32'(d_o_opcode),    32'd0);
        check("rst_exception", 32'(d_o_exception), 32'd0);
        @(negedge d_clk);
        d_rst     = 1'b0;
        d_i_ce    = 1'b0;
        exp_ce    = 1'b0;
        last_exp  = '0;
        sbq.delete();
        mon_en    = 1'b1;

        for (int n = 0; n < 200; n++)
            drive(rand_instr(), $urandom, ($urandom_range(0, 99) < 75),
                  ($urandom_range(0, 99) < 15), ($urandom_range(0, 99) < 10));
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        @(negedge d_clk);
        check("sb_drained", 32'(sbq.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
